// File: rtl/binder_hf.sv
// Hypervector bind unit: registers the bitwise XOR of two operand vectors
// together with a one-cycle-delayed valid strobe.
module binder_hf #(
   parameter int DIMENSIONS = 5
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  en,
   input  logic [DIMENSIONS-1:0] hv1,
   input  logic [DIMENSIONS-1:0] hv2,
   output logic                  out,
   output logic [DIMENSIONS-1:0] hv_out
);

   // Binding in this vector space is element-wise XOR; no bit interacts with another.
   function automatic logic [DIMENSIONS-1:0] bind_hv(
      input logic [DIMENSIONS-1:0] a,
      input logic [DIMENSIONS-1:0] b
   );
      return a ^ b;
   endfunction

   // Result and valid registers; the reset pin is active-high and clears both at once.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         out    <= 1'b0;
         hv_out <= {DIMENSIONS{1'b0}};
      end else begin
         out <= en;
         if (en) begin
            hv_out <= bind_hv(hv1, hv2);
         end else begin
            hv_out <= hv_out;
         end
      end
   end

endmodule

// File: tb/tb_binder_hf.sv
// Randomized self-checking bench for binder_hf at widths 5, 1 and 1024,
// compared against a per-bit behavioural reference model.
module tb_binder_hf;

   logic          clk = 1'b0;
   logic          nrst;
   logic          en;
   logic [4:0]    hv1_5, hv2_5;
   logic [0:0]    hv1_1, hv2_1;
   logic [1023:0] hv1_w, hv2_w;
   logic          out_5, out_1, out_w;
   logic [4:0]    hv_out_5;
   logic [0:0]    hv_out_1;
   logic [1023:0] hv_out_w;

   int checks = 0;
   int errors = 0;

   // reference state
   logic          m_out;
   logic [4:0]    m_hv5;
   logic [0:0]    m_hv1;
   logic [1023:0] m_hvw;

   always #5 clk = ~clk;

   binder_hf #(.DIMENSIONS(5)) u_dut5 (
      .clk(clk), .nrst(nrst), .en(en), .hv1(hv1_5), .hv2(hv2_5),
      .out(out_5), .hv_out(hv_out_5)
   );
   binder_hf #(.DIMENSIONS(1)) u_dut1 (
      .clk(clk), .nrst(nrst), .en(en), .hv1(hv1_1), .hv2(hv2_1),
      .out(out_1), .hv_out(hv_out_1)
   );
   binder_hf #(.DIMENSIONS(1024)) u_dut1024 (
      .clk(clk), .nrst(nrst), .en(en), .hv1(hv1_w), .hv2(hv2_w),
      .out(out_w), .hv_out(hv_out_w)
   );

   task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // bind reference: a result bit is 1 exactly when the two operand bits differ
   function automatic logic [1023:0] ref_bind(input logic [1023:0] a, input logic [1023:0] b, input int n);
      logic [1023:0] r;
      r = {1024{1'b0}};
      for (int i = 0; i < n; i++) r[i] = (a[i] != b[i]) ? 1'b1 : 1'b0;
      return r;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".out5"}, {1023'd0, out_5}, {1023'd0, m_out});
      check({tag, ".hv5"}, {1019'd0, hv_out_5}, {1019'd0, m_hv5});
      check({tag, ".out1"}, {1023'd0, out_1}, {1023'd0, m_out});
      check({tag, ".hv1"}, {1023'd0, hv_out_1}, {1023'd0, m_hv1});
      check({tag, ".out1024"}, {1023'd0, out_w}, {1023'd0, m_out});
      check({tag, ".hv1024"}, hv_out_w, m_hvw);
   endtask

   // one clock: drive at the falling edge, update the model at the rising edge, check 1 time unit later
   task automatic cycle(input logic r, input logic e, input logic [4:0] a, input logic [4:0] b, input string tag);
      @(negedge clk);
      nrst  = r;
      en    = e;
      hv1_5 = a;
      hv2_5 = b;
      hv1_1 = 1'($urandom);
      hv2_1 = 1'($urandom);
      for (int i = 0; i < 32; i++) begin
         hv1_w[i*32 +: 32] = $urandom;
         hv2_w[i*32 +: 32] = $urandom;
      end
      @(posedge clk);
      if (r) begin
         m_out = 1'b0;
         m_hv5 = 5'd0;
         m_hv1 = 1'b0;
         m_hvw = {1024{1'b0}};
      end else begin
         m_out = e;
         if (e) begin
            m_hv5 = 5'(ref_bind({1019'd0, a}, {1019'd0, b}, 5));
            m_hv1 = 1'(ref_bind({1023'd0, hv1_1}, {1023'd0, hv2_1}, 1));
            m_hvw = ref_bind(hv1_w, hv2_w, 1024);
         end
      end
      #1;
      check_all(tag);
   endtask

   logic [4:0] va [3];
   logic [4:0] vb [3];
   logic [4:0] vx [3];

   initial begin
      va[0] = 5'b11101; vb[0] = 5'b10010; vx[0] = 5'b01111;
      va[1] = 5'b00101; vb[1] = 5'b00111; vx[1] = 5'b00010;
      va[2] = 5'b11111; vb[2] = 5'b10110; vx[2] = 5'b01001;
      nrst = 1'b1;
      en   = 1'b0;
      hv1_5 = 5'd0; hv2_5 = 5'd0; hv1_1 = 1'b0; hv2_1 = 1'b0;
      hv1_w = {1024{1'b0}}; hv2_w = {1024{1'b0}};
      m_out = 1'b0; m_hv5 = 5'd0; m_hv1 = 1'b0; m_hvw = {1024{1'b0}};

      // reset held with en=1 must keep everything cleared
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b1, 5'($urandom), 5'($urandom), "reset");
         check("reset.const", {1019'd0, hv_out_5}, {1024{1'b0}});
      end

      // single binds, each followed by 9 idle cycles with changing operands
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b1, va[k], vb[k], "single");
         check("single.const", {1019'd0, hv_out_5}, {1019'd0, vx[k]});
         for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 5'($urandom), 5'($urandom), "idle");
         check("idle.const", {1019'd0, hv_out_5}, {1019'd0, vx[k]});
      end

      // hold
      cycle(1'b0, 1'b1, va[0], vb[0], "hold.bind");
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 5'($urandom), 5'($urandom), "hold");
      check("hold.const", {1019'd0, hv_out_5}, {1019'd0, 5'b01111});

      // back-to-back
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b1, va[k], vb[k], "b2b");
         check("b2b.const", {1019'd0, hv_out_5}, {1019'd0, vx[k]});
         check("b2b.out", {1023'd0, out_5}, {1023'd0, 1'b1});
      end
      cycle(1'b0, 1'b0, 5'($urandom), 5'($urandom), "b2b.end");

      // asynchronous reset in the cycle where out=1
      cycle(1'b0, 1'b1, va[0], vb[0], "mid.bind");
      #2;
      nrst = 1'b1;
      #1;
      m_out = 1'b0; m_hv5 = 5'd0; m_hv1 = 1'b0; m_hvw = {1024{1'b0}};
      check_all("mid.async");
      cycle(1'b0, 1'b1, va[1], vb[1], "mid.release");
      check("mid.release.const", {1019'd0, hv_out_5}, {1019'd0, vx[1]});
      cycle(1'b0, 1'b0, 5'($urandom), 5'($urandom), "mid.idle");

      // random traffic across all widths
      for (int i = 0; i < 60; i++)
         cycle(1'b0, 1'($urandom), 5'($urandom), 5'($urandom), "rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/binder_hf.md
BINDER_HF -- requirements
Module: binder_hf

Interface
REQ-001 SHALL provide parameter: DIMENSIONS, default 5, hypervector width in bits (legal range 1 to 10000).
REQ-002 SHALL provide port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port: nrst  input  1  reset; one clock; reset is asynchronous and active-high (nrst=1 resets).
REQ-004 SHALL provide port: en  input  1  bind request; operands are sampled on every rising edge where en=1.
REQ-005 SHALL provide port: hv1  input  DIMENSIONS  first operand hypervector.
REQ-006 SHALL provide port: hv2  input  DIMENSIONS  second operand hypervector.
REQ-007 SHALL provide port: out  output  1  result-valid strobe.
REQ-008 SHALL provide port: hv_out  output  DIMENSIONS  registered bound hypervector.

Function
REQ-009 SHALL compute the bind as the bitwise XOR, hv_out[i] = hv1[i] ^ hv2[i] for every i in 0..DIMENSIONS-1; no carries or cross-bit interaction.
REQ-010 SHALL register the result: on a rising edge with en=1 and reset deasserted, load hv_out with hv1^hv2 sampled at that edge (latency 1 cycle).
REQ-011 SHALL hold hv_out unchanged on every rising edge with en=0.
REQ-012 SHALL drive out as a registered copy of en: out=1 in the cycle after each edge where en=1, else 0.
REQ-013 SHALL pulse out for exactly one cycle for a single-cycle en.
REQ-014 SHALL hold out high continuously for back-to-back en cycles, loading a new hv_out on each such edge; throughput is one bind per cycle with no stall or backpressure.
REQ-015 SHALL have outputs depend only on registered state, with no combinational path from hv1, hv2 or en to hv_out or out.
REQ-016 SHALL ignore hv1/hv2 changes while en=0; they are never captured.
REQ-017 SHALL treat bit 0 as the LSB; no bit reordering.

Reset
REQ-018 SHALL, while nrst=1, force out=0 and hv_out=all zeros immediately, without waiting for a clock edge.
REQ-019 SHALL ignore en while nrst=1.
REQ-020 SHALL, if reset asserts mid-operation (including the cycle out=1), discard the pending result and clear both outputs.
REQ-021 SHALL, on the first rising edge after nrst deasserts, treat en=1 as a normal bind request.
REQ-022 SHALL NOT need an initial value other than the reset state; outputs are undefined only before the first reset.

Verification
REQ-023 SHALL pass reset: hold nrst=1 with en=1 and random operands for 10 cycles -> out=0, hv_out=00000 throughout; asynchronous clear observed mid-cycle.
REQ-024 SHALL pass single binds (DIMENSIONS=5), each a one-cycle en pulse followed by 9 idle cycles:
- hv1=11101, hv2=10010 -> hv_out=01111, out pulses 1 cycle.
- hv1=00101, hv2=00111 -> hv_out=00010.
- hv1=11111, hv2=10110 -> hv_out=01001.
- hv_out holds during idle cycles in each case.
REQ-025 SHALL pass hold: after a bind to 01111, set en=0 and toggle hv1/hv2 randomly for 20 cycles -> hv_out stays 01111, out stays 0.
REQ-026 SHALL pass back-to-back: en=1 for 3 consecutive cycles with the three operand pairs of REQ-024 -> out high 3 cycles; hv_out sequence 01111, 00010, 01001.
REQ-027 SHALL pass mid-operation reset: assert nrst asynchronously in the cycle out=1 -> out and hv_out clear immediately; the first bind after release behaves as in REQ-024.
REQ-028 SHALL pass width sweep: DIMENSIONS=1 and DIMENSIONS=1024 with random operands -> hv_out equals the bitwise XOR of the operands, checked against a model on every bind.
